// File: rtl/spi_master_pkg.sv
// Shared SPI definitions: state encoding, bus mode and counter sizing helper.
package spi_master_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_SHIFT = ST_SHIFT,
        S_HOLD  = ST_HOLD,
        S_GAP   = ST_GAP
    } state_t;

    // {CPOL, CPHA}; mode 0 only
    localparam logic [1:0] SPI_MODE = 2'b00;
    localparam logic       CPOL     = SPI_MODE[1];

    // Bits needed to count 0..n-1, never less than one
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: divides clk by CLK_DIV per half-period while enabled, idles at CPOL.
module spi_clk_gen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int                DIV_W = cnt_w(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // Pulses are high in the cycle whose closing edge moves sck
    assign tick       = enable && (div_cnt == DIV_LAST);
    assign rise_pulse = tick && (sck == CPOL);
    assign fall_pulse = tick && (sck != CPOL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sck     <= CPOL;
        end else if (!enable) begin
            div_cnt <= '0;
            sck     <= CPOL;
        end else if (tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one MSB-first word per start, with start/busy/done handshake.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_nss
);

    localparam int              BIT_W     = cnt_w(DATA_WIDTH + 1);
    localparam int              WAIT_MAX  = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int              WAIT_W    = cnt_w(WAIT_MAX);
    localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(DATA_WIDTH);
    localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(GAP - 1);

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  sck_en, rise, fall, accept, finish;

    // SETUP is simply the first low half-period of sck
    assign sck_en   = (state == S_SETUP) || (state == S_SHIFT);
    assign accept   = (state == S_IDLE) && start;
    assign finish   = (state == S_HOLD) && (state_nx == S_GAP);
    assign spi_mosi = tx_sh[DATA_WIDTH-1];

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (sck_en),
        .sck        (spi_sck),
        .rise_pulse (rise),
        .fall_pulse (fall)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_SETUP;
            S_SETUP: if (rise) state_nx = S_SHIFT;
            S_SHIFT: if (fall && (bit_cnt == BITS_LAST)) state_nx = S_HOLD;
            S_HOLD:  if (wait_cnt == HOLD_LAST) state_nx = S_GAP;
            S_GAP:   if (wait_cnt == GAP_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control: handshake and select registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_nss  <= 1'b1;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx != S_IDLE);
            done    <= finish;
            spi_nss <= (state_nx == S_IDLE) || (state_nx == S_GAP);
            if (state_nx != state)
                wait_cnt <= '0;
            else if ((state == S_HOLD) || (state == S_GAP))
                wait_cnt <= wait_cnt + 1'b1;
            if (accept)
                bit_cnt <= '0;
            else if (rise && (bit_cnt != BITS_LAST))
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // No shift after the final fall, so mosi keeps the LSB until the next word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh   <= '0;
            rx_data <= '0;
        end else begin
            if (accept)
                tx_sh <= tx_data;
            else if (fall && (state == S_SHIFT) && (bit_cnt != BITS_LAST))
                tx_sh <= tx_sh << 1;
            if (finish)
                rx_data <= rx_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rise)
            rx_sh <= DATA_WIDTH'({rx_sh, spi_miso});
    end

endmodule

// File: tb/tb_spi_master.sv
// Two SPI masters (defaults and a fast/wide corner) against a mode-0 slave model and scoreboard.
module tb_spi_master;

    logic clk;
    int   checks   = 0;
    int   failures = 0;
    bit   fin [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int          DV   = (g == 0) ? 4 : 2;
        localparam int          DW   = (g == 0) ? 8 : 16;
        localparam int          GP   = 4;
        localparam int          DUR  = DV * (2 * DW + 1);
        localparam logic [31:0] MASK = 32'((64'd1 << DW) - 64'd1);
        localparam logic [31:0] TXB  = (g == 0) ? 32'hA5 : 32'hBEEF;
        localparam logic [31:0] RXB  = (g == 0) ? 32'h3C : 32'h1234;

        logic          rst_n, start, busy, done, sck, mosi, miso, nss;
        logic [DW-1:0] tx_data, rx_data;

        int          cyc = 0;
        int          last_acc = -100000;
        int          next_free = 0;
        logic [31:0] q_tx [$];
        logic [31:0] q_rx [$];
        logic [31:0] slave_q [$];
        int          q_acc [$];
        int          q_done [$];

        logic [31:0] mosi_cap, word;
        int          rises, low_cnt, first_rise, last_rise, bitn, last_fall, last_done;
        bit          pend, in_x;
        logic        prev_sck, prev_mosi;

        spi_master #(.CLK_DIV(DV), .DATA_WIDTH(DW), .GAP(GP)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .tx_data  (tx_data),
            .busy     (busy),
            .done     (done),
            .rx_data  (rx_data),
            .spi_sck  (sck),
            .spi_mosi (mosi),
            .spi_miso (miso),
            .spi_nss  (nss)
        );

        always @(posedge clk) cyc <= cyc + 1;

        task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h at cycle %0d", g, nm, act, exp, cyc);
            end
        endtask

        // Drive one cycle; a start is taken iff the previous transfer's window has elapsed
        task automatic step(input bit st, input logic [31:0] tx, input logic [31:0] srx, output bit acc);
            int e;
            start   = st;
            tx_data = tx[DW-1:0];
            e       = cyc + 1;
            acc     = st && rst_n && (e >= next_free);
            if (acc) begin
                q_tx.push_back(tx & MASK);
                q_rx.push_back(srx & MASK);
                slave_q.push_back(srx & MASK);
                q_acc.push_back(e);
                q_done.push_back(e + DUR);
                last_acc  = e;
                next_free = e + DUR + GP + 1;
            end
            @(posedge clk);
            #1;
        endtask

        task automatic idle_until_free(input int extra);
            bit a;
            int n = 0;
            while ((cyc + 1 < next_free + extra) && (n < 2000)) begin
                step(1'b0, 32'h0, 32'h0, a);
                n++;
            end
            if (n >= 2000) begin
                checks++;
                failures++;
                $display("FAIL lane%0d idle_timeout: waited %0d cycles, required under 2000", g, n);
            end
        endtask

        // Slave: first bit on nss fall, next bit one cycle after each sck fall
        initial begin
            miso = 1'b0; prev_sck = 1'b0; pend = 1'b0; in_x = 1'b0;
            mosi_cap = '0; word = '0; rises = 0; low_cnt = 0; bitn = 0;
            first_rise = -1; last_rise = -1; last_fall = -1;
            forever begin
                @(posedge clk);
                #1;
                if (!rst_n || nss) begin
                    in_x = 1'b0;
                    pend = 1'b0;
                end else begin
                    if (!in_x) begin
                        in_x = 1'b1;
                        word = (slave_q.size() > 0) ? slave_q.pop_front() : 32'h0;
                        bitn = DW - 1;
                        miso = word[bitn];
                        rises = 0; low_cnt = 0; mosi_cap = '0;
                        first_rise = -1; last_rise = -1; last_fall = cyc;
                    end
                    low_cnt++;
                    if (sck && !prev_sck) begin
                        rises++;
                        mosi_cap = {mosi_cap[30:0], mosi};
                        if (first_rise < 0) first_rise = cyc;
                        last_rise = cyc;
                    end else if (!sck && prev_sck) begin
                        pend = 1'b1;
                    end else if (pend) begin
                        pend = 1'b0;
                        if (bitn > 0) begin
                            bitn--;
                            miso = word[bitn];
                        end
                    end
                end
                prev_sck = sck;
            end
        end

        // Monitor: per-cycle busy/nss window, mosi stability, and scoreboard on done
        initial begin : monitor
            bit busy_e, nss_low_e;
            int acc;
            prev_mosi = 1'b0;
            last_done = -1;
            forever begin
                @(posedge clk);
                #2;
                if (rst_n) begin
                    busy_e    = (cyc >= last_acc) && (cyc < last_acc + DUR + GP);
                    nss_low_e = (cyc >= last_acc) && (cyc < last_acc + DUR);
                    chk("busy", busy, busy_e);
                    chk("nss", nss, !nss_low_e);
                    if (mosi !== prev_mosi) chk("mosi_change_sck_low", sck, 1'b0);
                    if (done) begin
                        last_done = cyc;
                        if (q_tx.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL lane%0d unexpected_done: got done rx=0x%0h, required no done", g, rx_data);
                        end else begin
                            acc = q_acc.pop_front();
                            chk("done_cycle", cyc, q_done.pop_front());
                            chk("rx_data", rx_data, q_rx.pop_front());
                            chk("mosi_word", mosi_cap, q_tx.pop_front());
                            chk("sck_rises", rises, DW);
                            chk("nss_low_cycles", low_cnt, DUR);
                            chk("first_rise", first_rise, acc + DV);
                            chk("sck_period", last_rise - first_rise, 2 * DV * (DW - 1));
                        end
                    end
                end
                prev_mosi = mosi;
            end
        end

        initial begin : stim
            bit          a;
            int          acc0, n;
            logic [31:0] r1, r2;
            rst_n = 1'b0; start = 1'b0; tx_data = '0;
            repeat (3) @(posedge clk);
            #1;
            chk("rst_nss", nss, 1'b1);
            chk("rst_sck", sck, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_rx", rx_data, 32'h0);
            chk("rst_mosi", mosi, 1'b0);
            rst_n = 1'b1;

            // Basic transfer
            step(1'b1, TXB, RXB, a);
            idle_until_free(2);

            // Second start mid-transfer must be ignored
            step(1'b1, TXB, RXB, a);
            acc0 = last_acc;
            while (cyc + 1 < acc0 + 20) step(1'b0, 32'h0, 32'h0, a);
            step(1'b1, 32'hFFFF_FFFF, 32'h0, a);
            idle_until_free(2);
            chk("rx_after_reject", rx_data, RXB & MASK);

            // Back-to-back with start held high
            r1 = $urandom; r2 = $urandom;
            n = 0;
            do begin step(1'b1, 32'h01, r1, a); n++; end while (!a && n < 500);
            n = 0;
            do begin step(1'b1, 32'h80, r2, a); n++; end while (!a && n < 500);
            step(1'b0, 32'h0, 32'h0, a);
            chk("b2b_nss_gap", last_fall - last_done, GP + 1);
            idle_until_free(2);

            // Reset in the middle of a word, then restart with start already high
            step(1'b1, $urandom, $urandom, a);
            acc0 = last_acc;
            while (cyc + 1 < acc0 + 30) step(1'b0, 32'h0, 32'h0, a);
            rst_n = 1'b0;
            #1;
            chk("midrst_nss", nss, 1'b1);
            chk("midrst_sck", sck, 1'b0);
            chk("midrst_busy", busy, 1'b0);
            chk("midrst_done", done, 1'b0);
            chk("midrst_rx", rx_data, 32'h0);
            q_tx.delete(); q_rx.delete(); slave_q.delete(); q_acc.delete(); q_done.delete();
            last_acc = -100000; next_free = 0;
            start = 1'b1; tx_data = DW'(32'h5A);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            step(1'b1, 32'h5A, $urandom, a);
            idle_until_free(2);

            // Random traffic
            for (int i = 0; i < 1500; i++)
                step($urandom_range(0, 3) == 0, $urandom, $urandom, a);
            idle_until_free(3);
            chk("queue_drained", q_tx.size(), 0);
            fin[g] = 1'b1;
        end
    end

    initial begin : summary
        int t;
        t = 0;
        while (!(fin[0] && fin[1]) && t < 40000) begin
            @(posedge clk);
            t++;
        end
        if (!(fin[0] && fin[1])) begin
            checks++;
            failures++;
            $display("FAIL global_timeout: lanes finished %0d/%0d, required both", fin[0], fin[1]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
